alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WD_LIMIT, 64, max cycles in WAIT before the watchdog aborts the operation.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  instruction valid; in_ready  out  1  controller can accept.
REQ-005 in_op  in  6  ALU opcode, bits [5:1] are the operation code and bit 0 is passed through unchanged.
REQ-006 in_rd, in_ra, in_rb  in  3 each  destination and source register indices.
REQ-007 wr_en  in  1, wr_addr  in  3, wr_data  in  16  host register preload.
REQ-008 rd_addr  in  3, rd_data  out  16  combinational debug read of the register file.
REQ-009 alu_bgn  out  1, alu_opcode  out  6, alu_A  out  16, alu_B  out  16  drive the ALU.
REQ-010 alu_acc1, alu_acc2  in  16, alu_zero, alu_negative, alu_carry, alu_overflow  in  1, alu_rdy  in  1  ALU results.
REQ-011 flags  out  4  {Z,N,C,V} of the last completed op; busy  out  1; done  out  1; err  out  1.

Function
REQ-012 Register file: 8 x 16-bit, all entries writable.
REQ-013 The FSM has four states, IDLE, ISSUE, WAIT and WB, with the following transitions:
- IDLE->ISSUE on in_valid&in_ready.
- ISSUE->WAIT unconditionally.
- WAIT->WB on the alu_rdy rising edge.
- WAIT->IDLE on watchdog expiry.
- WB->IDLE unconditionally.
REQ-014 in_ready = 1 only in IDLE; busy = 1 in ISSUE, WAIT and WB.
REQ-015 On accept, the controller latches in_op and in_rd, plus reg[in_ra] and reg[in_rb] values as they are before any same-edge write.
REQ-016 alu_opcode, alu_A and alu_B are registered and are held stable from ISSUE until the FSM leaves WAIT.
- alu_opcode = latched op.
- alu_A = reg[ra].
- alu_B = reg[rb].
REQ-017 alu_bgn = 1 for exactly the single ISSUE cycle and 0 at all other times.
REQ-018 alu_rdy is sampled every cycle into rdy_q; completion is alu_rdy=1 & rdy_q=0 while in WAIT; a level-high alu_rdy already high on WAIT entry is not completion.
REQ-019 In WB, writeback depends on op[5:1]:
- 00111 (MUL) and 01000 (DIV): reg[rd] <= acc1 and reg[(rd+1) mod 8] <= acc2.
- 01110 (CMP), 01111 (TST) and 11111 (NOP): no register write.
- All other codes: reg[rd] <= acc1.
REQ-020 In WB, flags <= {zero,negative,carry,overflow} from the completion cycle, and done = 1 for exactly that one cycle.
REQ-021 Latency, for an ALU completing the cycle after bgn: accept edge k; ISSUE cycle k+1; completion detected in cycle k+2; WB cycle k+3; in_ready high cycle k+4.
REQ-022 The watchdog counter clears on ISSUE and increments each WAIT cycle; at count WD_LIMIT-1 without completion:
- err <= 1 (sticky until reset).
- No register or flags write and no done pulse.
- The FSM returns to IDLE.
REQ-023 The host write port is honoured only in IDLE and ignored in all other states.
REQ-024 A host write in the same IDLE cycle as an accept takes effect, but the operands use pre-write values (REQ-015).
REQ-025 An instruction with rd = ra or rd = rb is legal; sources are captured at accept, so writeback does not disturb the issued operands.
REQ-026 For MUL/DIV with rd = 7, the second write wraps to reg[0].

Reset
REQ-027 rst low asynchronously, at any state including mid-operation, forces:
- FSM to IDLE.
- All registers, flags, alu_opcode, alu_A, alu_B, rdy_q and the watchdog counter to 0.
- alu_bgn, done, err and busy to 0.
REQ-028 in_ready = 1 from the first edge after rst deasserts, and no writeback from an interrupted op ever occurs.

Verification
REQ-029 Preload r1=0x0005, r2=0x0003; issue ADD (op=6'b000010), rd=3 -> alu_bgn one cycle with A=5, B=3; r3=0x0008; done one pulse; flags Z=0.
REQ-030 Preload r4=0x1234, r5=0x0010; issue MUL, rd=7; ALU model returns acc1=0x2340, acc2=0x0001 -> r7=0x2340, r0=0x0001.
REQ-031 Issue CMP with r1=r2=0x00AA; ALU model returns zero=1 -> all registers unchanged; flags=4'b1000; done pulses.
REQ-032 ALU model holds alu_rdy=1 continuously; issue any op -> no completion, err=1 after 64 WAIT cycles; in_ready returns; destination register unchanged.
REQ-033 rst pulsed low during WAIT of a SUB to rd=2 (r2 preloaded 0x00FF) -> immediately alu_bgn=0, busy=0, r2=0; no done pulse follows.
REQ-034 In IDLE, present wr_en (addr 1, data 0x0009) and issue ADD ra=1 in the same cycle (r1 was 0x0002) -> alu_A=0x0002; r1=0x0009 afterward; wr_en asserted in WAIT is ignored.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Single-issue controller with an 8x16 register file, which drives
//           an external multi-cycle ALU and writes its results back.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WD_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_ra,
    input  logic [2:0]  in_rb,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        alu_bgn,
    output logic [5:0]  alu_opcode,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    input  logic [15:0] alu_acc1,
    input  logic [15:0] alu_acc2,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_rdy,
    output logic [3:0]  flags,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int         c_WD_W   = $clog2(WD_LIMIT + 1);
    localparam logic [4:0] c_OP_MUL = 5'b00111;
    localparam logic [4:0] c_OP_DIV = 5'b01000;
    localparam logic [4:0] c_OP_CMP = 5'b01110;
    localparam logic [4:0] c_OP_TST = 5'b01111;
    localparam logic [4:0] c_OP_NOP = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic [c_WD_W-1:0]   wd_q, wd_d;
    logic [5:0]          op_q, op_d;
    logic [2:0]          rd_q, rd_d;
    logic [15:0]         a_q, a_d;
    logic [15:0]         b_q, b_d;
    logic [15:0]         acc1_q, acc1_d;
    logic [15:0]         acc2_q, acc2_d;
    logic [3:0]          rflags_q, rflags_d;
    logic [3:0]          flags_q, flags_d;
    logic                err_q, err_d;
    logic [15:0]         regs_q [8];
    logic [15:0]         regs_d [8];
    logic                w_complete;

    // A level that was already high before WAIT is not a completion.
    assign w_complete = alu_rdy & ~rdy_q;

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        acc1_d   = acc1_q;
        acc2_d   = acc2_q;
        rflags_d = rflags_q;
        flags_d  = flags_q;
        err_d    = err_q;
        regs_d   = regs_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                end
                // Operands come from regs_q, so a same-edge host write is not seen.
                if (in_valid) begin
                    op_d    = in_op;
                    rd_d    = in_rd;
                    a_d     = regs_q[in_ra];
                    b_d     = regs_q[in_rb];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_complete) begin
                    acc1_d   = alu_acc1;
                    acc2_d   = alu_acc2;
                    rflags_d = {alu_zero, alu_negative, alu_carry, alu_overflow};
                    state_d  = S_WB;
                end else if (wd_q == c_WD_W'(WD_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + c_WD_W'(1);
                end
            end
            S_WB: begin
                flags_d = rflags_q;
                case (op_q[5:1])
                    c_OP_MUL, c_OP_DIV: begin
                        regs_d[rd_q]        = acc1_q;
                        regs_d[rd_q + 3'd1] = acc2_q;
                    end
                    c_OP_CMP, c_OP_TST, c_OP_NOP: ;
                    default: regs_d[rd_q] = acc1_q;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            wd_q     <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            rflags_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rdy_q    <= alu_rdy;
            wd_q     <= wd_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            rflags_q <= rflags_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign alu_bgn    = (state_q == S_ISSUE);
    assign done       = (state_q == S_WB);
    assign alu_opcode = op_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign flags      = flags_q;
    assign err        = err_q;
    assign rd_data    = regs_q[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed scoreboard bench for alu_issue_ctrl with a simple ALU model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [2:0]  in_rd = '0, in_ra = '0, in_rb = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        alu_bgn;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_A, alu_B;
    logic [15:0] alu_acc1 = '0, alu_acc2 = '0;
    logic        alu_zero = 1'b0, alu_negative = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
    logic        alu_rdy = 1'b0;
    logic [3:0]  flags;
    logic        busy, done, err;

    alu_issue_ctrl #(.WD_LIMIT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_A(alu_A), .alu_B(alu_B),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_rdy(alu_rdy),
        .flags(flags), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } iss_t;

    iss_t       exp_iss[$];
    logic [3:0] exp_flags[$];
    int         compared   = 0;
    int         mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected issue/completion records when the DUT presents them
    iss_t       mon_e;
    logic       flags_pend = 1'b0;
    logic [3:0] flags_exp_v = '0;
    always @(negedge clk) begin
        if (flags_pend) begin
            check("flags_after_done", flags, flags_exp_v);
            flags_pend = 1'b0;
        end
        if (rst && alu_bgn) begin
            if (exp_iss.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_bgn: got alu_bgn=1, expected no issue");
            end else begin
                mon_e = exp_iss.pop_front();
                check("alu_opcode", alu_opcode, mon_e.op);
                check("alu_A", alu_A, mon_e.a);
                check("alu_B", alu_B, mon_e.b);
            end
        end
        if (rst && done) begin
            if (exp_flags.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                flags_exp_v = exp_flags.pop_front();
                flags_pend  = 1'b1;
            end
        end
    end

    // ALU model: 0 = one-cycle rdy pulse after bgn, 1 = rdy held high, 2 = silent
    int          alu_mode = 0;
    logic [15:0] m_acc1 = '0, m_acc2 = '0;
    logic [3:0]  m_flags = '0;
    logic        pend = 1'b0;
    always @(negedge clk) if (alu_bgn) pend = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!rst || alu_mode != 0) pend = 1'b0;
        if (alu_mode == 1 || (alu_mode == 0 && pend)) begin
            alu_rdy = 1'b1;
            alu_acc1 = m_acc1;
            alu_acc2 = m_acc2;
            {alu_zero, alu_negative, alu_carry, alu_overflow} = m_flags;
            pend = 1'b0;
        end else begin
            alu_rdy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [2:0] a, input logic [15:0] e);
        rd_addr = a;
        #1;
        check(n, rd_data, e);
    endtask

    task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] ea, input logic [15:0] eb);
        iss_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin
            compared++; mismatched++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1");
        end
        e.op = op; e.a = ea; e.b = eb;
        exp_iss.push_back(e);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 200);
    endtask

    int lat;
    int n;
    logic err_at_65;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_bgn", alu_bgn, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_flags", flags, 0);
        rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        rd_chk("rst_r3", 3'd3, 16'h0000);

        // ADD r3 = r1 + r2
        host_wr(3'd1, 16'h0005);
        host_wr(3'd2, 16'h0003);
        m_acc1 = 16'h0008; m_acc2 = 16'h0000; m_flags = 4'b0000;
        exp_flags.push_back(4'b0000);
        issue(6'b000010, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003);
        wait_done(lat);
        check("add_latency", lat, 3);
        tick();
        check("add_in_ready", in_ready, 1);
        rd_chk("add_r3", 3'd3, 16'h0008);

        // MUL rd=7 wraps second write to r0
        host_wr(3'd4, 16'h1234);
        host_wr(3'd5, 16'h0010);
        m_acc1 = 16'h2340; m_acc2 = 16'h0001; m_flags = 4'b0000;
        exp_flags.push_back(4'b0000);
        issue(6'b001110, 3'd7, 3'd4, 3'd5, 16'h1234, 16'h0010);
        wait_done(lat);
        check("mul_latency", lat, 3);
        tick();
        rd_chk("mul_r7", 3'd7, 16'h2340);
        rd_chk("mul_r0", 3'd0, 16'h0001);

        // CMP: flags only
        host_wr(3'd1, 16'h00AA);
        host_wr(3'd2, 16'h00AA);
        m_acc1 = 16'hDEAD; m_acc2 = 16'hBEEF; m_flags = 4'b1000;
        exp_flags.push_back(4'b1000);
        issue(6'b011100, 3'd3, 3'd1, 3'd2, 16'h00AA, 16'h00AA);
        wait_done(lat);
        tick();
        rd_chk("cmp_r3", 3'd3, 16'h0008);
        rd_chk("cmp_r4", 3'd4, 16'h1234);
        rd_chk("cmp_r0", 3'd0, 16'h0001);

        // Host write on the accept edge; write during busy ignored
        host_wr(3'd1, 16'h0002);
        m_acc1 = 16'h00AC; m_acc2 = 16'h0000; m_flags = 4'b0000;
        exp_flags.push_back(4'b0000);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0009;
        issue(6'b000010, 3'd6, 3'd1, 3'd2, 16'h0002, 16'h00AA);
        wr_addr = 3'd5; wr_data = 16'hFFFF;
        wait_done(lat);
        wr_en = 1'b0;
        tick();
        rd_chk("same_cycle_r1", 3'd1, 16'h0009);
        rd_chk("busy_wr_r5", 3'd5, 16'h0010);
        rd_chk("same_cycle_r6", 3'd6, 16'h00AC);

        // Watchdog: rdy already high on WAIT entry never completes
        m_acc1 = 16'h0BAD; m_acc2 = 16'h0BAD; m_flags = 4'b0110;
        alu_mode = 1;
        tick(); tick();
        issue(6'b000110, 3'd4, 3'd1, 3'd2, 16'h0009, 16'h00AA);
        n = 0;
        err_at_65 = 1'bx;
        do begin
            @(negedge clk);
            n++;
            if (n == 65) err_at_65 = err;
        end while (!in_ready && n < 200);
        check("wd_return_cycle", n, 66);
        check("wd_err_before", err_at_65, 0);
        check("wd_err", err, 1);
        check("wd_flags", flags, 4'b0000);
        check("wd_done", done, 0);
        tick();
        rd_chk("wd_r4", 3'd4, 16'h1234);
        alu_mode = 2;

        // Reset in the middle of WAIT
        host_wr(3'd2, 16'h00FF);
        issue(6'b000100, 3'd2, 3'd1, 3'd2, 16'h0009, 16'h00FF);
        tick(); tick(); tick();
        rd_addr = 3'd2;
        #2;
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_bgn", alu_bgn, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_r2", rd_data, 16'h0000);
        check("mid_rst_err", err, 0);
        check("mid_rst_alu_A", alu_A, 0);
        tick(); tick();
        rst = 1'b1;
        alu_mode = 0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) tick();
        rd_chk("post_rst_r2", 3'd2, 16'h0000);
        check("post_rst_flags", flags, 0);

        check("iss_queue_drained", exp_iss.size(), 0);
        check("done_queue_drained", exp_flags.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
